// File: rtl/score_row_max_sub.sv
// Row max-subtract stage: buffers one row of scaled attention scores, tracks the
// signed row maximum, then replays the row as saturated (x - max) for the exp stage.
module score_row_max_sub #(
  parameter int WIDTH      = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int ROW_LEN    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH*LANES-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH*LANES-1:0]   out_data,
  output logic                     out_last,
  output logic [WIDTH-1:0]         out_max
);

  localparam int BEATS = ROW_LEN / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

  // Fixed-point format is shared by both operands, so it only constrains legality.
  if ((ROW_LEN % LANES) != 0 || ROW_LEN < LANES) begin : g_bad_row_len
    $error("ROW_LEN must be a nonzero multiple of LANES");
  end
  if (FRAC_WIDTH >= WIDTH) begin : g_bad_frac_width
    $error("FRAC_WIDTH must be smaller than WIDTH");
  end

  typedef enum logic {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_wr_cnt;
  logic [CNT_W-1:0]        r_rd_cnt;
  logic [WIDTH-1:0]        r_run_max;
  logic [WIDTH-1:0]        w_beat_max;
  logic [WIDTH*LANES-1:0]  r_buf [BEATS];
  logic [WIDTH*LANES-1:0]  w_rd_row;
  logic [WIDTH*LANES-1:0]  w_sub_data;
  logic                    w_in_fire;
  logic                    w_out_fire;

  // Difference fits in WIDTH+1 bits and is never positive; clamp anything below MIN.
  function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] d;
    d = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    return (d[WIDTH] != d[WIDTH-1]) ? MIN_VAL : d[WIDTH-1:0];
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid && (r_wr_cnt == LAST_BEAT)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && (r_rd_cnt == LAST_BEAT)) w_state_nxt = S_FILL;
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // NOTE: combinational logic uses blocking '=' so each lane sees the running
  // result of the previous one; clocked state below uses non-blocking '<='.
  always_comb begin
    w_beat_max = r_run_max;
    for (int i = 0; i < LANES; i++) begin
      if ($signed(in_data[i*WIDTH +: WIDTH]) > $signed(w_beat_max))
        w_beat_max = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FILL;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_run_max <= MIN_VAL;
    end else begin
      r_state <= w_state_nxt;
      if (w_in_fire) begin
        r_wr_cnt  <= (r_wr_cnt == LAST_BEAT) ? '0 : r_wr_cnt + CNT_W'(1);
        r_run_max <= w_beat_max;
      end
      if (w_out_fire) begin
        r_rd_cnt <= (r_rd_cnt == LAST_BEAT) ? '0 : r_rd_cnt + CNT_W'(1);
        if (r_rd_cnt == LAST_BEAT) r_run_max <= MIN_VAL;
      end
    end
  end

  // NOTE: the row buffer has no reset; every entry is rewritten during FILL
  // before DRAIN can read it, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (w_in_fire) r_buf[r_wr_cnt] <= in_data;
  end

  assign w_rd_row = r_buf[r_rd_cnt];

  always_comb begin
    w_sub_data = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sub_data[i*WIDTH +: WIDTH] = sat_sub(w_rd_row[i*WIDTH +: WIDTH], r_run_max);
    end
  end

  // Gate data outputs so they read as zero outside DRAIN.
  assign out_data = out_valid ? w_sub_data : '0;
  assign out_max  = out_valid ? r_run_max  : '0;
  assign out_last = out_valid && (r_rd_cnt == LAST_BEAT);

endmodule
